muldiv_unit: RTL and testbench

- Multi-cycle multiply/divide unit holding the architectural HI/LO pair. It extends the datapath ALU with MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- The unit is parametrised in operand width and uses an iterative radix-2 datapath: one bit per clock.
- The main datapath stalls on `busy` and reads `hi`/`lo` for MFHI/MFLO.

---
 rtl/muldiv_unit.sv | 166 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit owning the HI/LO register pair.
// One multiply or divide bit per clock; MTHI/MTLO complete in a single edge.
module muldiv_unit #(
  parameter  int WIDTH = 32,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t state, state_next;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc;      // product upper half / partial remainder
  logic [WIDTH-1:0] mq;       // multiplier or dividend, shifted one bit per cycle
  logic [WIDTH-1:0] opnd;     // multiplicand or divisor magnitude
  logic [WIDTH-1:0] a_raw;
  logic             is_div;
  logic             neg_q;
  logic             neg_r;
  logic             dz_pend;

  logic             signed_op;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH-1:0] div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0] q_fix, r_fix;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start && !op[2]) state_next = RUN;
      RUN:  if (cnt == CW'(1))   state_next = FIN;
      FIN:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // Operand magnitudes; the most-negative value maps to 2^(WIDTH-1), which is
  // exact as an unsigned WIDTH-bit quantity.
  always_comb begin
    signed_op = ~op[0];
    abs_a     = (signed_op && a[WIDTH-1]) ? (~a + 1'b1) : a;
    abs_b     = (signed_op && b[WIDTH-1]) ? (~b + 1'b1) : b;
  end

  always_comb begin
    mul_sum   = {1'b0, acc} + (mq[0] ? {1'b0, opnd} : '0);
    div_shift = {acc, mq[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, opnd});
    div_diff  = div_shift[WIDTH-1:0] - opnd;
    div_rem   = div_ge ? div_diff : div_shift[WIDTH-1:0];
  end

  always_comb begin
    prod     = {acc, mq};
    prod_fix = neg_q ? (~prod + 1'b1) : prod;
    q_fix    = neg_q ? (~mq + 1'b1) : mq;
    r_fix    = neg_r ? (~acc + 1'b1) : acc;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt      <= '0;
      acc      <= '0;
      mq       <= '0;
      opnd     <= '0;
      a_raw    <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      dz_pend  <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            case (op)
              OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                is_div   <= op[1];
                acc      <= '0;
                mq       <= abs_a;
                opnd     <= abs_b;
                a_raw    <= a;
                cnt      <= CW'(WIDTH);
                neg_q    <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
                neg_r    <= signed_op & a[WIDTH-1];
                dz_pend  <= op[1] & (b == '0);
                div_zero <= 1'b0;
              end
              OP_MTHI: begin
                hi       <= a;
                done     <= 1'b1;
                div_zero <= 1'b0;
              end
              OP_MTLO: begin
                lo       <= a;
                done     <= 1'b1;
                div_zero <= 1'b0;
              end
              default: ;
            endcase
          end
        end
        RUN: begin
          cnt <= cnt - 1'b1;
          if (is_div) begin
            acc <= div_rem;
            mq  <= {mq[WIDTH-2:0], div_ge};
          end else begin
            acc <= mul_sum[WIDTH:1];
            mq  <= {mul_sum[0], mq[WIDTH-1:1]};
          end
        end
        FIN: begin
          done <= 1'b1;
          if (dz_pend) begin
            lo       <= '1;
            hi       <= a_raw;
            div_zero <= 1'b1;
          end else if (is_div) begin
            lo <= q_fix;
            hi <= r_fix;
          end else begin
            {hi, lo} <= prod_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit at WIDTH=32 and WIDTH=8 with hand-computed results.
module tb_muldiv_unit;

  logic        clock;
  logic        reset;
  logic        start32, start8;
  logic [2:0]  op32, op8;
  logic [31:0] a32, b32;
  logic [7:0]  a8, b8;
  logic        busy32, done32, dz32, busy8, done8, dz8;
  logic [31:0] hi32, lo32;
  logic [7:0]  hi8, lo8;

  int tests = 0;
  int fails = 0;

  muldiv_unit #(.WIDTH(32)) dut32 (
    .clock(clock), .reset(reset), .start(start32), .op(op32), .a(a32), .b(b32),
    .busy(busy32), .done(done32), .div_zero(dz32), .hi(hi32), .lo(lo32)
  );

  muldiv_unit #(.WIDTH(8)) dut8 (
    .clock(clock), .reset(reset), .start(start8), .op(op8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .div_zero(dz8), .hi(hi8), .lo(lo8)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issues one multi-cycle op on the 32-bit unit and checks timing and result.
  task automatic run32(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_hi,
                       input logic [31:0] exp_lo, input logic exp_dz, input bit interfere);
    logic [31:0] prev_hi, prev_lo;
    bit hold_ok, got;
    int n;
    @(negedge clock);
    op32 = op; a32 = a; b32 = b; start32 = 1'b1;
    prev_hi = hi32; prev_lo = lo32;
    @(posedge clock); #1;
    chk({tag, " busy_after_start"}, busy32, 1);
    chk({tag, " dz_cleared"}, dz32, 0);
    @(negedge clock);
    start32 = 1'b0; a32 = 32'hDEAD_BEEF; b32 = 32'h0000_0013;
    hold_ok = 1; got = 0; n = 0;
    while (!got && n < 100) begin
      @(posedge clock); #1;
      n++;
      if (done32) got = 1;
      else begin
        if (!busy32 || hi32 !== prev_hi || lo32 !== prev_lo) hold_ok = 0;
        if (interfere && n == 5) begin
          start32 = 1'b1; op32 = 3'b011; a32 = 32'd50; b32 = 32'd3;
        end
        if (interfere && n == 10) start32 = 1'b0;
      end
    end
    chk({tag, " latency"}, n, 33);
    chk({tag, " hold_busy"}, hold_ok, 1);
    chk({tag, " hi"}, hi32, exp_hi);
    chk({tag, " lo"}, lo32, exp_lo);
    chk({tag, " div_zero"}, dz32, exp_dz);
    chk({tag, " busy_done"}, busy32, 0);
    @(posedge clock); #1;
    chk({tag, " done_one_cycle"}, done32, 0);
  endtask

  task automatic run8(input string tag, input logic [2:0] op, input logic [7:0] a,
                      input logic [7:0] b, input logic [7:0] exp_hi, input logic [7:0] exp_lo);
    bit got;
    int n;
    @(negedge clock);
    op8 = op; a8 = a; b8 = b; start8 = 1'b1;
    @(posedge clock); #1;
    @(negedge clock);
    start8 = 1'b0; a8 = 8'h5A; b8 = 8'h33;
    got = 0; n = 0;
    while (!got && n < 40) begin
      @(posedge clock); #1;
      n++;
      if (done8) got = 1;
    end
    chk({tag, " latency"}, n, 9);
    chk({tag, " hi"}, hi8, exp_hi);
    chk({tag, " lo"}, lo8, exp_lo);
  endtask

  task automatic mt32(input string tag, input logic [2:0] op, input logic [31:0] a,
                      input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    @(negedge clock);
    op32 = op; a32 = a; start32 = 1'b1;
    @(posedge clock); #1;
    chk({tag, " busy"}, busy32, 0);
    chk({tag, " done"}, done32, 1);
    chk({tag, " hi"}, hi32, exp_hi);
    chk({tag, " lo"}, lo32, exp_lo);
    @(negedge clock);
    start32 = 1'b0;
    @(posedge clock); #1;
    chk({tag, " done_one_cycle"}, done32, 0);
    chk({tag, " busy_after"}, busy32, 0);
  endtask

  initial begin
    int pulses;
    reset = 1'b1;
    start32 = 1'b0; op32 = '0; a32 = '0; b32 = '0;
    start8 = 1'b0;  op8 = '0;  a8 = '0;  b8 = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("reset hi", hi32, 0);
    chk("reset lo", lo32, 0);
    chk("reset busy", busy32, 0);
    chk("reset done", done32, 0);
    chk("reset dz", dz32, 0);
    @(negedge clock);
    reset = 1'b0;

    run32("multu_max", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0, 0);
    run32("mult_neg7x6", 3'b000, 32'hFFFF_FFF9, 32'd6, 32'hFFFF_FFFF, 32'hFFFF_FFD6, 0, 0);
    run32("mult_minxmin", 3'b000, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 0, 0);
    run32("div_neg7by2", 3'b010, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, 0);
    run32("divu_100by7", 3'b011, 32'd100, 32'd7, 32'd2, 32'd14, 0, 0);
    run32("div_minbym1", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 0, 0);
    run32("divu_5by0", 3'b011, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1, 0);
    run32("multu_3x4", 3'b001, 32'd3, 32'd4, 32'd0, 32'd12, 0, 0);

    mt32("mthi", 3'b100, 32'h0000_1234, 32'h0000_1234, 32'd12);
    mt32("mtlo", 3'b101, 32'h0000_ABCD, 32'h0000_1234, 32'h0000_ABCD);

    @(negedge clock);
    op32 = 3'b110; a32 = 32'h7777_7777; start32 = 1'b1;
    @(posedge clock); #1;
    chk("reserved busy", busy32, 0);
    chk("reserved done", done32, 0);
    chk("reserved hi", hi32, 32'h0000_1234);
    @(negedge clock);
    start32 = 1'b0;

    run32("multu_ignore_start", 3'b001, 32'h1234_5678, 32'h0000_0100,
          32'h0000_0012, 32'h3456_7800, 0, 1);

    @(negedge clock);
    op32 = 3'b001; a32 = 32'h55; b32 = 32'h33; start32 = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start32 = 1'b0;
    repeat (15) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
    chk("midrun_reset busy", busy32, 0);
    chk("midrun_reset hi", hi32, 0);
    chk("midrun_reset lo", lo32, 0);
    chk("midrun_reset done", done32, 0);
    @(negedge clock);
    reset = 1'b0;
    pulses = 0;
    repeat (40) begin
      @(posedge clock); #1;
      if (done32) pulses++;
    end
    chk("midrun_reset no_done", pulses, 0);
    run32("divu_9by3", 3'b011, 32'd9, 32'd3, 32'd0, 32'd3, 0, 0);

    run8("w8_multu_max", 3'b001, 8'hFF, 8'hFF, 8'hFE, 8'h01);
    run8("w8_div_neg7by2", 3'b010, 8'hF9, 8'h02, 8'hFF, 8'hFD);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
